// File: rtl/approx_div_pkg.sv
// approx_div_pkg
// Shared types and helpers for the approximate sequential divider.
//   state_t      : divider FSM states (IDLE, CALC, DONE)
//   exact_full   : exact full-subtractor cell, returns {bout, d}
//   exact_half   : exact half-subtractor cell (no borrow in), returns {bout, d}
//   approx_full  : approximate full-subtractor cell, returns {bout, d}
//   approx_half  : approximate half-subtractor cell, returns {bout, d}
//   clamp_lsbs   : limits the requested approximate-cell count to the row width
package approx_div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  function automatic logic [1:0] exact_full(input logic a, input logic b, input logic bin);
    return {(~a & b) | (bin & ~(a ^ b)), a ^ b ^ bin};
  endfunction

  function automatic logic [1:0] exact_half(input logic a, input logic b);
    return {~a & b, a ^ b};
  endfunction

  // The approximate cells drop the a/bin interaction in the borrow and
  // simplify the difference bit, which shortens the cell logic at the cost
  // of occasional wrong digits in the low positions.
  function automatic logic [1:0] approx_full(input logic a, input logic b, input logic bin);
    return {(~(a & b) & bin) | b, (a & b) ^ bin};
  endfunction

  function automatic logic [1:0] approx_half(input logic a, input logic b);
    return {b, a | b};
  endfunction

  function automatic int clamp_lsbs(input int lsbs, input int w);
    return (lsbs > w) ? w : lsbs;
  endfunction

endpackage

// File: rtl/approx_sub_row.sv
// approx_sub_row
// One row of W subtractor cells computing d = a - b with a ripple borrow.
// Cell 0 is a half cell; the rest are full cells. Each cell is exact or
// approximate according to its approx_mask bit.
//   a, b        : minuend and subtrahend (W bits)
//   approx_mask : per-cell select, 1 = approximate cell
//   d           : difference (W bits)
//   bout        : borrow out of the top cell (1 means a < b for exact cells)
module approx_sub_row
  import approx_div_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] approx_mask,
  output logic [W-1:0] d,
  output logic         bout
);

  // bc[j] is the borrow flowing into cell j; bc[W] leaves the row.
  logic [W:1] bc;

  for (genvar j = 0; j < W; j++) begin : g_cell
    logic [1:0] ex;
    logic [1:0] ap;
    if (j == 0) begin : g_half
      assign ex = exact_half(a[0], b[0]);
      assign ap = approx_half(a[0], b[0]);
    end else begin : g_full
      assign ex = exact_full(a[j], b[j], bc[j]);
      assign ap = approx_full(a[j], b[j], bc[j]);
    end
    assign {bc[j+1], d[j]} = approx_mask[j] ? ap : ex;
  end

  assign bout = bc[W];

endmodule

// File: rtl/approx_seq_divider.sv
// approx_seq_divider
// Iterative restoring divider: 2W-bit dividend / W-bit divisor, one quotient
// bit per clock, with a runtime-selectable number of approximate low cells
// in the trial subtractor.
//   clk, rst_n            : clock (rising edge), async active-low reset
//   in_valid / in_ready   : operand handshake
//   dividend, divisor     : operands (2W and W bits)
//   approx_en, approx_lsbs: approximation mode, captured at accept
//   out_valid / out_ready : result handshake
//   quotient, remainder   : result (W bits each)
//   ovf, dbz              : quotient overflow, divide by zero (implies ovf)
module approx_seq_divider
  import approx_div_pkg::*;
#(
  parameter int W  = 8,
  parameter int AW = $clog2(W + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2*W-1:0]  dividend,
  input  logic [W-1:0]    divisor,
  input  logic            approx_en,
  input  logic [AW-1:0]   approx_lsbs,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    quotient,
  output logic [W-1:0]    remainder,
  output logic            ovf,
  output logic            dbz
);

  localparam int CW = $clog2(W);

  state_t          state;
  logic [W-1:0]    p;
  logic [W-1:0]    s;
  logic [CW-1:0]   cnt;
  logic [W-1:0]    divisor_r;
  logic            approx_en_r;
  logic [AW-1:0]   approx_lsbs_r;

  logic [W-1:0]    mask;
  logic [W-1:0]    t;
  logic [W-1:0]    d_row;
  logic            bout_row;
  logic            qb;
  logic [W-1:0]    p_next;
  logic [W-1:0]    s_next;
  int              lsbs_lim;

  assign lsbs_lim = clamp_lsbs(int'(approx_lsbs_r), W);

  // Cells below the clamped count are approximate, but only while the
  // captured enable is set.
  always_comb begin
    mask = '0;
    for (int j = 0; j < W; j++) begin
      mask[j] = approx_en_r && (j < lsbs_lim);
    end
  end

  // Shift the next dividend bit into the partial remainder and trial-subtract.
  // The bit shifted out of P (top) means T really has W+1 bits, so the
  // subtraction always succeeds when it is set.
  assign t      = {p[W-2:0], s[W-1]};
  assign qb     = p[W-1] | ~bout_row;
  assign p_next = qb ? d_row : t;
  assign s_next = {s[W-2:0], qb};

  approx_sub_row #(.W(W)) u_row (
    .a           (t),
    .b           (divisor_r),
    .approx_mask (mask),
    .d           (d_row),
    .bout        (bout_row)
  );

  // FSM with registered handshake and result outputs. Overflowing or
  // divide-by-zero operands skip CALC and finish straight away.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      in_ready      <= 1'b1;
      out_valid     <= 1'b0;
      quotient      <= '0;
      remainder     <= '0;
      ovf           <= 1'b0;
      dbz           <= 1'b0;
      p             <= '0;
      s             <= '0;
      cnt           <= '0;
      divisor_r     <= '0;
      approx_en_r   <= 1'b0;
      approx_lsbs_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            divisor_r     <= divisor;
            approx_en_r   <= approx_en;
            approx_lsbs_r <= approx_lsbs;
            in_ready      <= 1'b0;
            if (dividend[2*W-1:W] >= divisor) begin
              ovf       <= 1'b1;
              dbz       <= (divisor == '0);
              quotient  <= '0;
              remainder <= dividend[W-1:0];
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              ovf   <= 1'b0;
              dbz   <= 1'b0;
              p     <= dividend[2*W-1:W];
              s     <= dividend[W-1:0];
              cnt   <= '0;
              state <= CALC;
            end
          end
        end
        CALC: begin
          p   <= p_next;
          s   <= s_next;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(W - 1)) begin
            quotient  <= s_next;
            remainder <= p_next;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_approx_seq_divider.sv
// tb_approx_seq_divider
// Self-checking bench for approx_seq_divider (W = 8): directed cases,
// randomized operands against a behavioural division model, backpressure,
// and reset in the middle of an operation.
module tb_approx_seq_divider;

  localparam int W  = 8;
  localparam int AW = $clog2(W + 1);

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [2*W-1:0]  dividend;
  logic [W-1:0]    divisor;
  logic            approx_en;
  logic [AW-1:0]   approx_lsbs;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    quotient;
  logic [W-1:0]    remainder;
  logic            ovf;
  logic            dbz;

  int checks = 0;
  int errors = 0;

  approx_seq_divider #(.W(W), .AW(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .approx_en   (approx_en),
    .approx_lsbs (approx_lsbs),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .ovf         (ovf),
    .dbz         (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something leaves the bench waiting forever.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("[TB] FAIL %s got 0x%0h expected 0x%0h", tag, got, expv);
    end
  endtask

  // Reference: overflow rule, then either plain integer division or, when
  // approximate cells are in use, W restoring steps whose trial subtraction
  // is evaluated cell by cell from the cell truth equations.
  task automatic refDiv(input int dd, input int dv, input bit en, input int ls,
                        output int q, output int r, output int ov, output int dz);
    int hi, lo, lim, pr, sr, tr, top, bin, dres, a, b, dbit, bo, qbit;
    hi  = dd / 256;
    lo  = dd % 256;
    lim = (ls > W) ? W : ls;
    dz  = (dv == 0);
    ov  = (hi >= dv);
    if (ov != 0) begin
      q = 0;
      r = lo;
    end else if (!en || lim == 0) begin
      q = dd / dv;
      r = dd % dv;
    end else begin
      pr = hi;
      sr = lo;
      for (int k = 0; k < W; k++) begin
        top  = pr / 128;
        tr   = ((pr * 2) % 256) + (sr / 128);
        bin  = 0;
        dres = 0;
        for (int j = 0; j < W; j++) begin
          a = (tr >> j) & 1;
          b = (dv >> j) & 1;
          if (j == 0) begin
            if (lim > 0) begin dbit = a | b; bo = b; end
            else begin dbit = a ^ b; bo = (1 - a) & b; end
          end else if (j < lim) begin
            dbit = (a & b) ^ bin;
            bo   = ((1 - (a & b)) & bin) | b;
          end else begin
            dbit = a ^ b ^ bin;
            bo   = ((1 - a) & b) | (bin & (1 - (a ^ b)));
          end
          dres = dres + (dbit << j);
          bin  = bo;
        end
        qbit = top | (1 - bin);
        pr   = qbit ? dres : tr;
        sr   = ((sr * 2) % 256) + qbit;
      end
      q = sr;
      r = pr;
    end
  endtask

  // Presents one operation, waits for it to be accepted and for its result,
  // and returns the result plus the number of edges from accept to out_valid.
  // Assumes it is called 1 time unit after a rising edge; leaves out_ready low.
  task automatic applyStimulus(input logic [2*W-1:0] dd, input logic [W-1:0] dv,
                               input logic en, input logic [AW-1:0] ls,
                               output int lat, output logic [W-1:0] q,
                               output logic [W-1:0] r, output logic ov, output logic dz);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) checkOutput("accept_timeout", 32'(in_ready), 32'd1);
    dividend    = dd;
    divisor     = dv;
    approx_en   = en;
    approx_lsbs = ls;
    in_valid    = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    dividend = 16'(~dd);
    divisor  = 8'(~dv);
    lat = 1;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    q  = quotient;
    r  = remainder;
    ov = ovf;
    dz = dbz;
  endtask

  task automatic finishOp();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic runRandom(input int n, input bit en, input int ls);
    int lat, eq, er, eo, ez;
    logic [W-1:0] q, r;
    logic ov, dz;
    logic [2*W-1:0] dd;
    logic [W-1:0] dv;
    for (int i = 0; i < n; i++) begin
      dv = 8'($urandom_range(1, 255));
      dd = {8'($urandom_range(0, int'(dv) - 1)), 8'($urandom)};
      applyStimulus(dd, dv, en, 4'(ls), lat, q, r, ov, dz);
      refDiv(int'(dd), int'(dv), en, ls, eq, er, eo, ez);
      checkOutput($sformatf("rand_q en%0d ls%0d", en, ls), 32'(q), 32'(eq));
      checkOutput($sformatf("rand_r en%0d ls%0d", en, ls), 32'(r), 32'(er));
      checkOutput($sformatf("rand_ovf en%0d ls%0d", en, ls), 32'(ov), 32'(eo));
      finishOp();
    end
  endtask

  initial begin
    int lat, eq, er, eo, ez, n;
    logic [W-1:0] q, r, hq, hr;
    logic ov, dz;

    rst_n       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    dividend    = '0;
    divisor     = '0;
    approx_en   = 1'b0;
    approx_lsbs = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_quotient", 32'(quotient), 32'd0);
    checkOutput("reset_remainder", 32'(remainder), 32'd0);
    checkOutput("reset_ovf", 32'(ovf), 32'd0);
    checkOutput("reset_dbz", 32'(dbz), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] directed cases");
    applyStimulus(16'h03E8, 8'd7, 1'b0, 4'd0, lat, q, r, ov, dz);
    checkOutput("exact_q", 32'(q), 32'd142);
    checkOutput("exact_r", 32'(r), 32'd6);
    checkOutput("exact_ovf", 32'(ov), 32'd0);
    checkOutput("exact_dbz", 32'(dz), 32'd0);
    checkOutput("exact_latency", 32'(lat), 32'(W + 1));
    finishOp();

    applyStimulus(16'h0800, 8'h08, 1'b0, 4'd0, lat, q, r, ov, dz);
    checkOutput("ovf_q", 32'(q), 32'd0);
    checkOutput("ovf_r", 32'(r), 32'h00);
    checkOutput("ovf_ovf", 32'(ov), 32'd1);
    checkOutput("ovf_dbz", 32'(dz), 32'd0);
    checkOutput("ovf_latency", 32'(lat), 32'd1);
    finishOp();

    applyStimulus(16'h1234, 8'h00, 1'b0, 4'd0, lat, q, r, ov, dz);
    checkOutput("dbz_q", 32'(q), 32'd0);
    checkOutput("dbz_r", 32'(r), 32'h34);
    checkOutput("dbz_ovf", 32'(ov), 32'd1);
    checkOutput("dbz_dbz", 32'(dz), 32'd1);
    checkOutput("dbz_latency", 32'(lat), 32'd1);
    finishOp();

    $display("[TB] random operands");
    runRandom(1000, 1'b1, 0);
    runRandom(100, 1'b0, 15);
    runRandom(200, 1'b1, 3);
    runRandom(200, 1'b1, 15);
    runRandom(50, 1'b1, 8);

    $display("[TB] backpressure and busy");
    dividend    = 16'h3039;
    divisor     = 8'h71;
    approx_en   = 1'b0;
    approx_lsbs = '0;
    in_valid    = 1'b1;
    @(posedge clk); #1;
    dividend = 16'h0001;
    divisor  = 8'h02;
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = 4;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("busy_latency", 32'(n), 32'(W + 1));
    checkOutput("busy_q", 32'(quotient), 32'(12345 / 113));
    checkOutput("busy_r", 32'(remainder), 32'(12345 % 113));
    hq = quotient;
    hr = remainder;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checkOutput("hold_valid", 32'(out_valid), 32'd1);
      checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
      checkOutput("hold_q", 32'(quotient), 32'(hq));
      checkOutput("hold_r", 32'(remainder), 32'(hr));
    end
    finishOp();
    checkOutput("b2b_in_ready", 32'(in_ready), 32'd1);
    checkOutput("b2b_out_valid", 32'(out_valid), 32'd0);
    applyStimulus(16'h7FFF, 8'hC8, 1'b0, 4'd0, lat, q, r, ov, dz);
    checkOutput("b2b_q", 32'(q), 32'(32767 / 200));
    checkOutput("b2b_r", 32'(r), 32'(32767 % 200));
    checkOutput("b2b_latency", 32'(lat), 32'(W + 1));
    finishOp();

    // Leave a nonzero result in the output registers before the reset test.
    applyStimulus(16'h2710, 8'h33, 1'b1, 4'd2, lat, q, r, ov, dz);
    refDiv(16'h2710, 8'h33, 1'b1, 2, eq, er, eo, ez);
    checkOutput("pre_reset_q", 32'(q), 32'(eq));
    finishOp();

    $display("[TB] reset mid-operation");
    dividend    = 16'h4E20;
    divisor     = 8'hA7;
    approx_en   = 1'b0;
    approx_lsbs = '0;
    in_valid    = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_quotient", 32'(quotient), 32'd0);
    checkOutput("midrst_remainder", 32'(remainder), 32'd0);
    checkOutput("midrst_ovf", 32'(ovf), 32'd0);
    checkOutput("midrst_dbz", 32'(dbz), 32'd0);
    @(posedge clk); #1;
    checkOutput("midrst_hold_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus(16'h4E20, 8'hA7, 1'b0, 4'd0, lat, q, r, ov, dz);
    checkOutput("postrst_q", 32'(q), 32'(20000 / 167));
    checkOutput("postrst_r", 32'(r), 32'(20000 % 167));
    checkOutput("postrst_latency", 32'(lat), 32'(W + 1));
    finishOp();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
